// File: rtl/apu_env_pkg.sv
// Shared constants for the APU envelope unit: DIN field positions and decay maximum.
package apu_env_pkg;

    function automatic int loop_bit(input int w);
        return w + 1;
    endfunction

    function automatic int const_bit(input int w);
        return w;
    endfunction

    function automatic int decay_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/apu_env_div.sv
// Reloadable down-counter dividing the quarter-frame rate by V+1.
// Count output present only with APU_ENVELOPE_DBG_EN.
module apu_env_div #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         nRES,
    input  logic         ce,
    input  logic         reload,
    input  logic [W-1:0] reload_val,
`ifdef APU_ENVELOPE_DBG_EN
    output logic [W-1:0] cnt,
`endif
    output logic         zero
);

    logic [W-1:0] cnt_q;

    assign zero = (cnt_q == '0);

`ifdef APU_ENVELOPE_DBG_EN
    assign cnt = cnt_q;
`endif

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            cnt_q <= '0;
        end else if (ce) begin
            if (reload || zero) begin
                cnt_q <= reload_val;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/apu_envelope.sv
// APU envelope generator: start flag, divider and decay counter on quarter-frame.
// Optional debug outputs enabled by defining APU_ENVELOPE_DBG_EN.
module apu_envelope
    import apu_env_pkg::*;
#(
    parameter int VOL_W = 4
) (
    input  logic             CLK,
    input  logic             nRES,
    input  logic             nLFO1,
    input  logic             WR_CTRL,
    input  logic             WR_LEN,
    input  logic [VOL_W+1:0] DIN,
`ifdef APU_ENVELOPE_DBG_EN
    output logic [VOL_W-1:0] DBG_DECAY,
    output logic [VOL_W-1:0] DBG_DIV,
    output logic             DBG_START,
`endif
    output logic [VOL_W-1:0] VOL,
    output logic             LOOP
);

    localparam int LOOP_BIT = loop_bit(VOL_W);
    localparam int CONST_BIT = const_bit(VOL_W);
    localparam logic [VOL_W-1:0] C_MAX = VOL_W'(decay_max(VOL_W));

    logic             lfo_prev;
    logic             qf;
    logic             loop_q;
    logic             const_q;
    logic [VOL_W-1:0] v_q;
    logic             start_q;
    logic [VOL_W-1:0] decay_q;
    logic             div_zero;

    // Falling edge of nLFO1; a held low level fires only once.
    assign qf = lfo_prev & ~nLFO1;

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            lfo_prev <= 1'b1;
        end else begin
            lfo_prev <= nLFO1;
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            loop_q  <= 1'b0;
            const_q <= 1'b0;
            v_q     <= '0;
        end else if (WR_CTRL) begin
            loop_q  <= DIN[LOOP_BIT];
            const_q <= DIN[CONST_BIT];
            v_q     <= DIN[VOL_W-1:0];
        end
    end

    // A length write wins over the clear done by a coincident quarter-frame.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            start_q <= 1'b0;
        end else if (WR_LEN) begin
            start_q <= 1'b1;
        end else if (qf) begin
            start_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            decay_q <= '0;
        end else if (qf) begin
            if (start_q) begin
                decay_q <= C_MAX;
            end else if (div_zero) begin
                if (decay_q != '0) begin
                    decay_q <= decay_q - 1'b1;
                end else if (loop_q) begin
                    decay_q <= C_MAX;
                end
            end
        end
    end

    apu_env_div #(
        .W(VOL_W)
    ) u_div (
        .CLK        (CLK),
        .nRES       (nRES),
        .ce         (qf),
        .reload     (start_q),
        .reload_val (v_q),
`ifdef APU_ENVELOPE_DBG_EN
        .cnt        (DBG_DIV),
`endif
        .zero       (div_zero)
    );

    assign VOL  = const_q ? v_q : decay_q;
    assign LOOP = loop_q;

`ifdef APU_ENVELOPE_DBG_EN
    assign DBG_DECAY = decay_q;
    assign DBG_START = start_q;
`endif

endmodule

// File: doc/apu_envelope.md
APU_ENVELOPE -- requirements
Module: apu_envelope

Interface
REQ-001 SHALL have parameter VOL_W, default 4, setting the width of volume, divider and decay counter.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRES, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port nLFO1, input, 1, quarter-frame signal from the LFO generator, inverse polarity (0 = trigger level).
REQ-005 SHALL have port WR_CTRL, input, 1, strobe: latch DIN into control register this cycle.
REQ-006 SHALL have port WR_LEN, input, 1, strobe: length-register write; sets start flag.
REQ-007 SHALL have port DIN, input, VOL_W+2, bit VOL_W+1 = LOOP, bit VOL_W = CONST, bits VOL_W-1:0 = V.
REQ-008 SHALL have port VOL, output, VOL_W, envelope volume to the channel DAC mux.
REQ-009 SHALL have port LOOP, output, 1, registered loop bit, also used as length-counter halt.

Function
REQ-010 SHALL form the quarter-frame event QF as a one-CLK pulse on each 1->0 transition of nLFO1 (prev register, reset 1); a held low level SHALL produce exactly one QF.
REQ-011 SHALL hold state: control {LOOP, CONST, V}, start flag S, divider D, decay counter C, all VOL_W wide where applicable.
REQ-012 On QF with S=1: clear S, set C = 2^VOL_W-1, set D = V.
REQ-013 On QF with S=0 and D=0: set D = V; if C>0 decrement C, else if LOOP=1 set C = 2^VOL_W-1, else hold C = 0.
REQ-014 On QF with S=0 and D>0: decrement D only.
REQ-015 Without QF, D, C and S SHALL hold, except S per REQ-016.
REQ-016 WR_LEN SHALL set S=1 on the next edge; with simultaneous QF, QF SHALL use the old S, and S SHALL end at 1.
REQ-017 WR_CTRL with simultaneous QF: QF SHALL use the old V and LOOP; new control visible from next cycle.
REQ-018 VOL SHALL be combinational from registers: CONST=1 -> V, else C; no extra latency beyond the register update.
REQ-019 Arithmetic SHALL be unsigned VOL_W-bit; decrement never wraps below 0 (guarded by REQ-013/014).

Reset
REQ-020 On nRES=0, asynchronously: control=0, S=0, D=0, C=0, nLFO1 prev=1; hence VOL=0, LOOP=0.
REQ-021 Reset asserted mid-sequence SHALL discard pending S and partial divider count; after release the first QF SHALL follow REQ-013 with D=0 and C=0.
REQ-022 Strobes and QF during reset SHALL be ignored.

Configuration
REQ-023 Macro APU_ENVELOPE_DBG_EN: when defined, SHALL add outputs DBG_DECAY (VOL_W, = C) and DBG_DIV (VOL_W, = D) and DBG_START (1, = S); when undefined, these ports and their logic SHALL be absent and function SHALL be unchanged.

Structure
REQ-024 Shared package apu_env_pkg SHALL hold DIN bit-position constants (LOOP_BIT, CONST_BIT) and the decay-max constant as a function of VOL_W.
REQ-025 Divider SHALL be a sub-module apu_env_div: reloadable VOL_W-bit down-counter with inputs clk-enable (QF), reload, reload value; output zero flag.

Verification
REQ-026 nRES=0 while DIN/strobes toggle -> VOL=0, LOOP=0 throughout; release -> still 0.
REQ-027 WR_CTRL DIN={0,0,V=3}, WR_LEN, then 1 nLFO1 falling edge -> VOL=15; every 4 further edges VOL decrements, reaching 0 after 60 more edges and holding at 0.
REQ-028 Same with LOOP=1, V=0 -> VOL steps 15,14..0,15 once per edge (wrap after 16 edges post-start).
REQ-029 DIN={0,1,V=9} -> VOL=9 immediately after write, independent of QF; nLFO1 held low 10 CLKs -> DBG_DIV changes once only.
REQ-030 WR_LEN coincident with QF while S=0, C=5, D=0 -> C=4 that cycle; next QF -> C=15.
REQ-031 nRES pulsed low mid-decay (C=7, D=2) -> all zero; next QF with V=1 -> D=1, C=0.
